// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
// Framer state encoding, parity-mode constants and bit-period math.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // clock cycles per line bit; 0 flags an unusable baud rate
   function automatic int unsigned calc_div(
      input int unsigned clk_freq,
      input int unsigned baud
   );
      return (baud == 0) ? 0 : clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: valid/ready word handshake into the framer.
// The producer holds the master side, the framer the slave side.
interface uart_tx_framer_if #(
   parameter int W = 8
) ();

   logic [W-1:0] data_in;
   logic         data_valid;
   logic         data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );

endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period timer for the transmit framer.
// tick is high in the last cycle of every DIV-cycle bit period.
module uart_baud_counter #(
   parameter int unsigned DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   // count 0..DIV-1, restarting at wrap or whenever the framer clears
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one word per frame onto tx.
// Frame = start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ       = 32'd100000000,
   parameter int unsigned BAUDRATE       = 32'd9600,
   parameter int          NO_OF_DATABITS = 8,
   parameter int          NO_OF_STOPBITS = 1,
   parameter int          PARITY_MODE    = 0
) (
   input  logic              clk,
   input  logic              reset,
   uart_tx_framer_if.slave   s_if,
   output logic              busy,
   output logic              frame_done,
   output logic              tx
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUDRATE);
   localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);
   localparam logic [3:0] LAST_DATA = 4'(NO_OF_DATABITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(NO_OF_STOPBITS - 1);

   if (NO_OF_DATABITS < 5 || NO_OF_DATABITS > 9) begin : g_bad_nb
      $error("uart_tx_framer: NO_OF_DATABITS must be 5..9");
   end
   if (NO_OF_STOPBITS < 1 || NO_OF_STOPBITS > 2) begin : g_bad_ns
      $error("uart_tx_framer: NO_OF_STOPBITS must be 1 or 2");
   end
   if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_pm
      $error("uart_tx_framer: PARITY_MODE must be 0, 1 or 2");
   end
   if (DIV < 1) begin : g_bad_div
      $error("uart_tx_framer: CLK_FREQ/BAUDRATE must be at least 1");
   end

   uart_state_t                r_state;
   uart_state_t                w_state_nxt;
   logic [NO_OF_DATABITS-1:0]  r_shift;
   logic [NO_OF_DATABITS-1:0]  w_shift_nxt;
   logic [3:0]                 r_bitcnt;
   logic                       r_par;
   logic                       r_tx;
   logic                       r_busy;
   logic                       w_tx_nxt;
   logic                       w_busy_nxt;
   logic                       w_tick;
   logic                       w_clear;
   logic                       w_ready;
   logic                       w_accept;
   logic                       w_trans;

   assign w_ready  = !r_busy && !reset;
   assign w_accept = w_ready && s_if.data_valid;
   assign w_trans  = (w_state_nxt != r_state);
   // hold the timer at 0 while idle so every frame starts phase-aligned
   assign w_clear  = w_trans || (r_state == ST_IDLE);

   assign s_if.data_ready = w_ready;
   assign busy = r_busy;
   assign tx   = r_tx;

   uart_baud_counter #(
      .DIV (DIV)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state: each line bit ends on a baud tick
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_tick) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_tick && r_bitcnt == LAST_DATA)
               w_state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (w_tick) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_tick && r_bitcnt == LAST_STOP)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // outputs: next line level and busy, registered below
   always_comb begin
      w_shift_nxt = r_shift;
      if (w_accept) begin
         w_shift_nxt = s_if.data_in;
      end else if (r_state == ST_DATA && w_tick) begin
         w_shift_nxt = r_shift >> 1;
      end
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      w_tx_nxt   = 1'b1;
      unique case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
         ST_PARITY: w_tx_nxt = r_par;
         default:   w_tx_nxt = 1'b1;
      endcase
      frame_done = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
   end

   // datapath: shift register, parity, bit counter, output flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_bitcnt <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_shift <= w_shift_nxt;
         if (w_accept) begin
            r_par <= (^s_if.data_in) ^ (PARITY_MODE == PARITY_ODD);
         end
         if (w_trans) begin
            r_bitcnt <= '0;
         end else if (w_tick &&
                      (r_state == ST_DATA || r_state == ST_STOP)) begin
            r_bitcnt <= r_bitcnt + 1'b1;
         end
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
      end
   end

endmodule
